// File: rtl/fun_arbiter.sv
// fun_arbiter
//
// Shares one fun unit (result = a * cbrt(b)) among N_REQ requesters.
// A round-robin pick captures the winner's operands, a one-cycle start is
// issued, and the arbiter waits for the unit to drop busy. The result is then
// returned with a one-hot done pulse to the winner. If busy never drops, a
// watchdog resets the unit and returns an errored, zero result instead.
//
// Ports
//   clk, rst       : single clock, synchronous active-high reset
//   req_i          : per-requester request level
//   a_i, b_i       : packed 8-bit operands, requester k at [8k+7:8k]
//   gnt_o          : one-hot pulse when a requester's operands are captured
//   done_o         : one-hot pulse when that requester's result is presented
//   err_o          : high with done_o when the operation timed out
//   result_o       : 11-bit result, valid in the done_o cycle, held otherwise
//   fun_a_o/_b_o   : latched operands to the fun unit
//   fun_start_o    : start strobe to the fun unit
//   fun_rst_o      : reset to the fun unit (rst or watchdog recovery)
//   fun_busy_i     : busy from the fun unit
//   fun_result_i   : result from the fun unit
//
// State     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | scan requests from ptr, capture winner's operands
// S_ISSUE   | start strobe + grant pulse, advance ptr, clear watchdog
// S_WAIT    | wait for busy to drop, or for the watchdog to expire
// S_DONE    | done pulse to the winner with the captured result
// S_RECOVER | reset the fun unit, done pulse with err and zero result

module fun_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [8*N_REQ-1:0]   a_i,
    input  logic [8*N_REQ-1:0]   b_i,
    output logic [N_REQ-1:0]     gnt_o,
    output logic [N_REQ-1:0]     done_o,
    output logic                 err_o,
    output logic [10:0]          result_o,
    output logic [7:0]           fun_a_o,
    output logic [7:0]           fun_b_o,
    output logic                 fun_start_o,
    output logic                 fun_rst_o,
    input  logic                 fun_busy_i,
    input  logic [10:0]          fun_result_i
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_RECOVER
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_sel;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_fun_a;
    logic [7:0]      r_fun_b;
    logic [10:0]     r_result;

    logic            w_any;
    logic [PW-1:0]   w_pick;
    logic [PW-1:0]   w_cand;
    logic [7:0]      w_a_pick;
    logic [7:0]      w_b_pick;
    logic [N_REQ-1:0] w_sel_oh;
    logic            w_recover;
    logic            w_timeout;

    // Index base+off modulo N_REQ, with off < N_REQ so one subtraction suffices.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return PW'(s);
    endfunction

    // Round-robin pick: first set request scanning upward from ptr, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = wrap_add(r_ptr, i);
            if (!w_any && req_i[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_a_pick  = a_i[8*int'(w_pick) +: 8];
    assign w_b_pick  = b_i[8*int'(w_pick) +: 8];
    assign w_sel_oh  = N_REQ'(1) << r_sel;

    // Completion is checked before expiry so a busy drop on the last
    // watchdog cycle still completes normally.
    assign w_timeout = fun_busy_i && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        gnt_o       = '0;
        done_o      = '0;
        err_o       = 1'b0;
        fun_start_o = 1'b0;
        w_recover   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fun_start_o = 1'b1;
                gnt_o       = w_sel_oh;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (!fun_busy_i) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_RECOVER;
                end
            end
            S_DONE: begin
                done_o = w_sel_oh;
                w_next = S_IDLE;
            end
            S_RECOVER: begin
                done_o    = w_sel_oh;
                err_o     = 1'b1;
                w_recover = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_fun_a  <= '0;
            r_fun_b  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_pick;
                        r_fun_a <= w_a_pick;
                        r_fun_b <= w_b_pick;
                    end
                end
                S_ISSUE: begin
                    r_ptr <= (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    if (!fun_busy_i) begin
                        r_result <= fun_result_i;
                    end else if (w_timeout) begin
                        // Zeroed on entry so RECOVER presents a zero result.
                        r_result <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o  = r_result;
    assign fun_a_o   = r_fun_a;
    assign fun_b_o   = r_fun_b;
    assign fun_rst_o = rst | w_recover;

endmodule

// File: tb/tb_fun_arbiter.sv
module tb_fun_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic        err_o;
    logic [10:0] result_o;
    logic [7:0]  fun_a_o;
    logic [7:0]  fun_b_o;
    logic        fun_start_o;
    logic        fun_rst_o;
    logic        fun_busy_i = 1'b0;
    logic [10:0] fun_result_i = '0;

    fun_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .result_o     (result_o),
        .fun_a_o      (fun_a_o),
        .fun_b_o      (fun_b_o),
        .fun_start_o  (fun_start_o),
        .fun_rst_o    (fun_rst_o),
        .fun_busy_i   (fun_busy_i),
        .fun_result_i (fun_result_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- fun unit stub ----------------
    int lat   = 3;
    bit stuck = 1'b0;
    int fcnt  = 0;

    function automatic int cbrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    always @(posedge clk) begin
        if (fun_rst_o) begin
            fun_busy_i <= 1'b0;
            fcnt       <= 0;
        end else if (fun_start_o) begin
            fun_busy_i   <= 1'b1;
            fcnt         <= lat;
            fun_result_i <= 11'(int'(fun_a_o) * cbrt(int'(fun_b_o)));
        end else if (fun_busy_i && !stuck) begin
            if (fcnt <= 1) fun_busy_i <= 1'b0;
            else           fcnt <= fcnt - 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int idx; int a; int b; } gexp_t;
    typedef struct { int idx; int err; int res; int lat; } dexp_t;
    gexp_t gq[$];
    dexp_t dq[$];
    gexp_t ge;
    dexp_t de;
    int cyc = 0;
    int g_cyc = 0;
    int starts = 0;
    int rst_pulses = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst && fun_rst_o)   rst_pulses++;
        if (!rst && fun_start_o) starts++;
        if (gnt_o != 0) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", int'(gnt_o), 0);
            end else begin
                ge = gq.pop_front();
                chk("gnt", int'(gnt_o), 1 << ge.idx);
                chk("gnt_fun_a", int'(fun_a_o), ge.a);
                chk("gnt_fun_b", int'(fun_b_o), ge.b);
                chk("gnt_start", int'(fun_start_o), 1);
                g_cyc = cyc;
            end
        end
        if (done_o != 0) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", int'(done_o), 0);
            end else begin
                de = dq.pop_front();
                chk("done", int'(done_o), 1 << de.idx);
                chk("done_err", int'(err_o), de.err);
                chk("done_result", int'(result_o), de.res);
                chk("done_latency", cyc - g_cyc, de.lat);
                chk("done_fun_rst", int'(fun_rst_o), de.err);
            end
        end
    end

    // ---------------- stimulus ----------------
    int rem[4];

    function automatic bit rem_any();
        return (rem[0] != 0) || (rem[1] != 0) || (rem[2] != 0) || (rem[3] != 0);
    endfunction

    // Requests are held until the requester's own done, for rem operations.
    task automatic step();
        @(posedge clk);
        #2;
        for (int k = 0; k < 4; k++) begin
            if (done_o[k] && rem[k] > 0) begin
                rem[k]--;
                if (rem[k] == 0) req_i[k] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int k, input int a, input int b, input int n);
        a_i[8*k +: 8] = 8'(a);
        b_i[8*k +: 8] = 8'(b);
        req_i[k]      = 1'b1;
        rem[k]        = n;
    endtask

    task automatic exp_op(input int k, input int a, input int b, input int err,
                          input int res, input int l);
        gexp_t g;
        dexp_t d;
        g.idx = k; g.a = a; g.b = b;
        d.idx = k; d.err = err; d.res = res; d.lat = l;
        gq.push_back(g);
        dq.push_back(d);
    endtask

    task automatic run_quiet(input int budget);
        int n;
        n = 0;
        while ((rem_any() || gq.size() != 0 || dq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("quiet_budget", int'(n >= budget), 0);
        repeat (2) step();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"}, int'(gnt_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_err"}, int'(err_o), 0);
        chk({tag, "_result"}, int'(result_o), 0);
        chk({tag, "_fun_a"}, int'(fun_a_o), 0);
        chk({tag, "_fun_b"}, int'(fun_b_o), 0);
        chk({tag, "_start"}, int'(fun_start_o), 0);
        chk({tag, "_fun_rst"}, int'(fun_rst_o), 1);
    endtask

    int p0;

    initial begin
        rst = 1'b1; req_i = '0; a_i = '0; b_i = '0;
        for (int k = 0; k < 4; k++) rem[k] = 0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        rst = 1'b0;
        step();
        chk("fun_rst_released", int'(fun_rst_o), 0);

        // Single requester
        exp_op(0, 5, 27, 0, 15, 5);
        set_req(0, 5, 27, 1);
        step();
        chk("gnt_latency", int'(gnt_o), 4'b0001);
        run_quiet(100);
        exp_op(0, 255, 200, 0, 1275, 5);
        set_req(0, 255, 200, 1);
        run_quiet(100);

        // Fresh pointer for the simultaneous case
        rst = 1'b1; step(); rst = 1'b0; step();

        // Simultaneous requests, grant order 0,1,2,3
        exp_op(0, 3, 64, 0, 12, 5);
        exp_op(1, 9, 125, 0, 45, 5);
        exp_op(2, 97, 0, 0, 0, 5);
        exp_op(3, 84, 84, 0, 336, 5);
        set_req(0, 3, 64, 1);
        set_req(1, 9, 125, 1);
        set_req(2, 97, 0, 1);
        set_req(3, 84, 84, 1);
        run_quiet(200);

        // Fairness: 0 and 2 held for three operations each
        for (int i = 0; i < 3; i++) begin
            exp_op(0, 2, 8, 0, 4, 5);
            exp_op(2, 10, 1, 0, 10, 5);
        end
        set_req(0, 2, 8, 3);
        set_req(2, 10, 1, 3);
        run_quiet(200);

        // Withdrawal: req1 pulses for one cycle during WAIT
        exp_op(0, 7, 64, 0, 28, 5);
        set_req(0, 7, 64, 1);
        step();
        step();
        a_i[15:8] = 8'd50; b_i[15:8] = 8'd50; req_i[1] = 1'b1;
        step();
        req_i[1] = 1'b0;
        run_quiet(100);

        // Busy drops on the last watchdog cycle: completion wins
        lat = 15;
        exp_op(0, 3, 27, 0, 9, 17);
        set_req(0, 3, 27, 1);
        run_quiet(100);

        // Timeout with busy stuck high
        lat = 3; stuck = 1'b1;
        p0 = rst_pulses;
        exp_op(1, 1, 1, 1, 0, 17);
        set_req(1, 1, 1, 1);
        run_quiet(100);
        stuck = 1'b0;
        chk("recover_pulses", rst_pulses - p0, 1);
        exp_op(2, 6, 8, 0, 12, 5);
        set_req(2, 6, 8, 1);
        run_quiet(100);

        // Reset in the middle of WAIT
        lat = 6;
        begin
            gexp_t g;
            g.idx = 3; g.a = 44; g.b = 255;
            gq.push_back(g);
        end
        set_req(3, 44, 255, 1);
        step();
        step();
        step();
        rst = 1'b1; req_i[3] = 1'b0; rem[3] = 0;
        step();
        check_reset_vals("midwait");
        rst = 1'b0;
        repeat (10) step();
        exp_op(3, 44, 255, 0, 264, 8);
        set_req(3, 44, 255, 1);
        run_quiet(100);

        chk("gq_empty", gq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        chk("start_count", starts, 18);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
